// File: rtl/threshold_pkg.sv
// Shared types and gray extraction for the camera-path thresholder.
// Used by both the threshold controller and the thresholder datapath.
package threshold_pkg;

    localparam int GRAY_W = 8;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_AUTO   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_SMOOTH = 2'd3
    } state_e;

    function automatic logic [GRAY_W-1:0] gray_of(
        input logic [15:0] d1,
        input logic [15:0] d2
    );
        return {d1[15], d1[1:0], d2[15], d2[11:10], d2[1:0]};
    endfunction

    function automatic mode_e mode_next(input mode_e m);
        case (m)
            MODE_BYPASS: return MODE_MANUAL;
            MODE_MANUAL: return MODE_AUTO;
            default:     return MODE_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/frame_minmax_tracker.sv
// Running min/max of gray values within one frame.
// A clear cycle may also carry the frame's first pixel.
module frame_minmax_tracker
    import threshold_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [GRAY_W-1:0] gray,
    output logic [GRAY_W-1:0] gray_min,
    output logic [GRAY_W-1:0] gray_max,
    output logic              any_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_min  <= '1;
            gray_max  <= '0;
            any_valid <= 1'b0;
        end else if (clear) begin
            gray_min  <= valid ? gray : '1;
            gray_max  <= valid ? gray : '0;
            any_valid <= valid;
        end else if (valid) begin
            if (gray < gray_min) gray_min <= gray;
            if (gray > gray_max) gray_max <= gray;
            any_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/auto_threshold_ctrl.sv
// Frame-synchronous enable/threshold sequencer for the binary thresholder.
// Threshold and mode only move at frame boundaries so frames never tear.
module auto_threshold_ctrl
    import threshold_pkg::*;
#(
    parameter logic [7:0] DEFAULT_THR = 8'd128,
    parameter int         ALPHA_SHIFT = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFrameStart,
    input  logic        iFrameEnd,
    input  logic        iDVAL,
    input  logic [15:0] iData1,
    input  logic [15:0] iData2,
    input  logic        iModeStep,
    input  logic [7:0]  iManualThr,
    output logic        oEnable,
    output logic [7:0]  oThreshold,
    output logic [1:0]  oMode,
    output logic [7:0]  oFrameMin,
    output logic [7:0]  oFrameMax,
    output logic        oBusy
);

    state_e            state, state_n;
    mode_e             mode, mode_pend;
    logic              start_pend;
    logic              clear, take_pixel;
    logic [GRAY_W-1:0] gray, trk_min, trk_max;
    logic              trk_any;
    logic [7:0]        thr, target, fmin, fmax;
    logic              enable, busy;
    logic [8:0]        sum;
    logic signed [8:0] diff, step;
    logic [7:0]        thr_auto;

    assign gray = gray_of(iData1, iData2);

    frame_minmax_tracker u_tracker (
        .clk       (iCLK),
        .rst       (iRST),
        .clear     (clear),
        .valid     (take_pixel),
        .gray      (gray),
        .gray_min  (trk_min),
        .gray_max  (trk_max),
        .any_valid (trk_any)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        clear      = 1'b0;
        take_pixel = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iFrameStart) begin
                    state_n    = ST_ACCUM;
                    clear      = 1'b1;
                    take_pixel = iDVAL;
                end
            end
            ST_ACCUM: begin
                take_pixel = iDVAL;
                // End wins over a coincident start; the start is deferred
                if (iFrameEnd)        state_n = ST_UPDATE;
                else if (iFrameStart) clear   = 1'b1;
            end
            ST_UPDATE: state_n = ST_SMOOTH;
            ST_SMOOTH: begin
                if (start_pend || iFrameStart) begin
                    state_n = ST_ACCUM;
                    clear   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            start_pend <= 1'b0;
        end else if (state == ST_SMOOTH) begin
            start_pend <= 1'b0;
        end else if (iFrameStart && (state == ST_UPDATE ||
                     (state == ST_ACCUM && iFrameEnd))) begin
            start_pend <= 1'b1;
        end
    end

    assign sum  = {1'b0, trk_min} + {1'b0, trk_max};
    assign diff = $signed({1'b0, target}) - $signed({1'b0, thr});

    // Shift toward target, but never stall short of it
    always_comb begin
        step = diff >>> ALPHA_SHIFT;
        if (step == '0 && diff != '0)
            step = diff[8] ? 9'h1FF : 9'h001;
        thr_auto = thr + step[7:0];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode      <= MODE_BYPASS;
            mode_pend <= MODE_BYPASS;
            enable    <= 1'b0;
            thr       <= DEFAULT_THR;
            target    <= DEFAULT_THR;
            fmin      <= 8'hFF;
            fmax      <= 8'h00;
            busy      <= 1'b0;
        end else begin
            busy <= (state_n == ST_UPDATE) || (state_n == ST_SMOOTH);
            if (iModeStep) mode_pend <= mode_next(mode_pend);
            if (state == ST_UPDATE && trk_any) begin
                fmin   <= trk_min;
                fmax   <= trk_max;
                target <= sum[8:1];
            end
            if (state == ST_SMOOTH) begin
                mode <= mode_pend;
                unique case (mode_pend)
                    MODE_BYPASS: enable <= 1'b0;
                    MODE_MANUAL: begin
                        enable <= 1'b1;
                        thr    <= iManualThr;
                    end
                    MODE_AUTO: begin
                        enable <= 1'b1;
                        if (trk_any) thr <= thr_auto;
                    end
                    default: enable <= 1'b0;
                endcase
            end
        end
    end

    assign oEnable    = enable;
    assign oThreshold = thr;
    assign oMode      = mode;
    assign oFrameMin  = fmin;
    assign oFrameMax  = fmax;
    assign oBusy      = busy;

endmodule

// File: tb/tb_auto_threshold_ctrl.sv
// Directed plus randomized frames against a per-frame reference model.
// Two instances cover immediate (shift 0) and smoothed (shift 2) auto mode.
module tb_auto_threshold_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fs, fe, dval, mstep;
    logic [15:0] d1, d2;
    logic [7:0]  man;
    logic        en0, en2, busy0, busy2;
    logic [7:0]  thr0, thr2, mn0, mn2, mx0, mx2;
    logic [1:0]  md0, md2;

    auto_threshold_ctrl #(.DEFAULT_THR(8'd128), .ALPHA_SHIFT(0)) dut0 (
        .iCLK(clk), .iRST(rst), .iFrameStart(fs), .iFrameEnd(fe),
        .iDVAL(dval), .iData1(d1), .iData2(d2), .iModeStep(mstep),
        .iManualThr(man), .oEnable(en0), .oThreshold(thr0), .oMode(md0),
        .oFrameMin(mn0), .oFrameMax(mx0), .oBusy(busy0)
    );

    auto_threshold_ctrl #(.DEFAULT_THR(8'd128), .ALPHA_SHIFT(2)) dut2 (
        .iCLK(clk), .iRST(rst), .iFrameStart(fs), .iFrameEnd(fe),
        .iDVAL(dval), .iData1(d1), .iData2(d2), .iModeStep(mstep),
        .iManualThr(man), .oEnable(en2), .oThreshold(thr2), .oMode(md2),
        .oFrameMin(mn2), .oFrameMax(mx2), .oBusy(busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode, m_pend, m_en, m_min, m_max, m_thr0, m_thr2;
    int px[$];
    int seq200[3] = '{146, 159, 169};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iir(input int thr, input int tgt, input int sh);
        int d, q, s;
        d = tgt - thr;
        q = 1 << sh;
        if (d >= 0) s = d / q;
        else        s = -((-d + q - 1) / q);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return thr + s;
    endfunction

    task automatic model_boundary();
        int lo, hi;
        lo = 255;
        hi = 0;
        m_mode = m_pend;
        foreach (px[i]) begin
            if (px[i] < lo) lo = px[i];
            if (px[i] > hi) hi = px[i];
        end
        if (px.size() > 0) begin
            m_min = lo;
            m_max = hi;
        end
        case (m_mode)
            0: m_en = 0;
            1: begin
                m_en   = 1;
                m_thr0 = int'(man);
                m_thr2 = int'(man);
            end
            default: begin
                m_en = 1;
                if (px.size() > 0) begin
                    m_thr0 = iir(m_thr0, (lo + hi) / 2, 0);
                    m_thr2 = iir(m_thr2, (lo + hi) / 2, 2);
                end
            end
        endcase
        px.delete();
    endtask

    task automatic check_all(input string t);
        check({t, ".thr0"}, thr0, m_thr0);
        check({t, ".thr2"}, thr2, m_thr2);
        check({t, ".en0"}, en0, m_en);
        check({t, ".en2"}, en2, m_en);
        check({t, ".mode0"}, md0, m_mode);
        check({t, ".mode2"}, md2, m_mode);
        check({t, ".min"}, mn0, m_min);
        check({t, ".max"}, mx2, m_max);
        check({t, ".busy0"}, busy0, 0);
        check({t, ".busy2"}, busy2, 0);
    endtask

    task automatic drive_pix(input int g);
        logic [7:0]  b;
        logic [15:0] w1, w2;
        b  = g[7:0];
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        w1[15]    = b[7];
        w1[1:0]   = b[6:5];
        w2[15]    = b[4];
        w2[11:10] = b[3:2];
        w2[1:0]   = b[1:0];
        d1   = w1;
        d2   = w2;
        dval = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        m_mode = 0;
        m_pend = 0;
        m_en   = 0;
        m_min  = 255;
        m_max  = 0;
        m_thr0 = 128;
        m_thr2 = 128;
        px.delete();
    endtask

    task automatic start_frame(input bit with_pix, input int g);
        fs = 1'b1;
        px.delete();
        if (with_pix) begin
            drive_pix(g);
            px.push_back(g);
        end
        tick();
        fs   = 1'b0;
        dval = 1'b0;
    endtask

    task automatic pixel(input int g);
        drive_pix(g);
        px.push_back(g);
        tick();
        dval = 1'b0;
    endtask

    task automatic step_mode();
        mstep  = 1'b1;
        m_pend = (m_pend + 1) % 3;
        tick();
        mstep = 1'b0;
    endtask

    task automatic end_frame(input string t, input bit with_pix,
                             input int g, input bit also_start);
        fe = 1'b1;
        fs = also_start;
        if (with_pix) begin
            drive_pix(g);
            px.push_back(g);
        end
        tick();
        fe   = 1'b0;
        fs   = 1'b0;
        dval = 1'b0;
        check({t, ".busy_upd"}, busy2, 1);
        tick();
        check({t, ".busy_smooth"}, busy0, 1);
        check({t, ".thr_hold"}, thr2, m_thr2);
        check({t, ".mode_hold"}, md0, m_mode);
        tick();
        model_boundary();
        check_all(t);
    endtask

    initial begin
        rst   = 1'b1;
        fs    = 1'b0;
        fe    = 1'b0;
        dval  = 1'b0;
        mstep = 1'b0;
        d1    = '0;
        d2    = '0;
        man   = 8'd200;

        do_reset();
        check_all("reset");
        check("reset.thr_const", thr0, 128);

        step_mode();
        step_mode();
        idle(2);
        check("mode_deferred", md0, 0);

        start_frame(1, 128);
        pixel(130);
        end_frame("minstep", 0, 0, 0);
        check("minstep.thr2_const", thr2, 129);

        start_frame(1, 40);
        for (int i = 0; i < 10; i++) pixel($urandom_range(41, 199));
        end_frame("spread", 1, 200, 0);
        check("spread.thr0_const", thr0, 120);
        check("spread.min_const", mn2, 40);
        check("spread.max_const", mx0, 200);

        do_reset();
        step_mode();
        start_frame(1, 60);
        pixel(10);
        do_reset();
        check_all("rst_mid");
        drive_pix(5);
        tick();
        dval = 1'b0;
        fe   = 1'b1;
        tick();
        fe = 1'b0;
        idle(3);
        check_all("rst_ignored");

        step_mode();
        step_mode();
        for (int i = 0; i < 3; i++) begin
            start_frame(1, 200);
            pixel(200);
            end_frame("to200", 1, 200, 0);
            check("to200.thr2_const", thr2, seq200[i]);
        end

        start_frame(1, 0);
        pixel(0);
        pixel(250);
        start_frame(1, 50);
        for (int i = 0; i < 6; i++) pixel($urandom_range(60, 100));
        end_frame("restart", 1, 100, 0);
        check("restart.min_const", mn0, 50);

        start_frame(0, 0);
        idle(4);
        end_frame("empty_auto", 0, 0, 0);

        start_frame(1, 30);
        pixel(90);
        end_frame("same_cycle", 1, 70, 1);
        pixel(150);
        pixel(170);
        end_frame("after_same", 0, 0, 0);
        check("after_same.min_const", mn2, 150);

        start_frame(1, 80);
        step_mode();
        pixel(90);
        step_mode();
        step_mode();
        end_frame("wrap", 1, 100, 0);
        check("wrap.mode_const", md2, 2);

        start_frame(1, 20);
        step_mode();
        pixel(220);
        check("bypass.mode_mid", md0, 2);
        end_frame("bypass", 0, 0, 0);
        check("bypass.en_const", en0, 0);

        step_mode();
        start_frame(1, 10);
        pixel(20);
        man = 8'd77;
        pixel(30);
        check("manual.thr_mid", thr0, m_thr0);
        end_frame("manual", 0, 0, 0);
        check("manual.thr_const", thr2, 77);

        man = 8'd33;
        start_frame(0, 0);
        idle(2);
        end_frame("manual_empty", 0, 0, 0);

        for (int f = 0; f < 25; f++) begin
            int np;
            int ns;
            np = $urandom_range(0, 12);
            ns = $urandom_range(0, 3);
            start_frame(np > 0, $urandom_range(0, 255));
            for (int j = 1; j < np; j++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                pixel($urandom_range(0, 255));
            end
            repeat (ns) step_mode();
            man = 8'($urandom);
            end_frame("random", 1'($urandom_range(0, 1)),
                      $urandom_range(0, 255), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
